// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared widths, output limits and saturation helper for the PID demo
package pid_pkg;

    localparam int IN_W   = 10;
    localparam int GAIN_W = 4;
    localparam int OUT_W  = 15;
    localparam int ERR_W  = 11;
    localparam int ACC_W  = 21;

    localparam int OUT_MAX = 16383;
    localparam int OUT_MIN = -16384;

    // Clamp a full-precision accumulator value into the output range.
    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = ACC_W'(OUT_MAX);
        lo = ACC_W'(OUT_MIN);
        if (a > hi) begin
            return OUT_W'(OUT_MAX);
        end else if (a < lo) begin
            return OUT_W'(OUT_MIN);
        end else begin
            return a[OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pid_core.sv
// rtl/pid_core.sv - velocity-form PID: error history, increment and saturating accumulator
module pid_core
    import pid_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   target,
    input  logic signed [IN_W-1:0]   y,
    input  logic        [GAIN_W-1:0] kp,
    input  logic        [GAIN_W-1:0] ki,
    input  logic        [GAIN_W-1:0] kd,
    output logic signed [OUT_W-1:0]  uk0
);

    logic signed [ERR_W-1:0] e0_q, e0_d;
    logic signed [ERR_W-1:0] e1_q, e1_d;
    logic signed [ERR_W-1:0] e2_q, e2_d;
    logic signed [OUT_W-1:0] uk0_q, uk0_d;

    logic signed [ERR_W-1:0]  e;
    logic signed [ERR_W:0]    dp;
    logic signed [ERR_W+1:0]  dd;
    logic signed [GAIN_W:0]   kp_s, ki_s, kd_s;
    logic signed [ACC_W-1:0]  du;
    logic signed [ACC_W-1:0]  sum;

    always_comb begin
        e    = ERR_W'(target) - ERR_W'(y);
        dp   = (ERR_W+1)'(e0_q) - (ERR_W+1)'(e1_q);
        dd   = (ERR_W+2)'(e0_q) - ((ERR_W+2)'(e1_q) <<< 1) + (ERR_W+2)'(e2_q);
        // Gains are unsigned; a zero MSB keeps them non-negative in signed products.
        kp_s = signed'({1'b0, kp});
        ki_s = signed'({1'b0, ki});
        kd_s = signed'({1'b0, kd});
        du   = ACC_W'(kp_s) * ACC_W'(dp)
             + ACC_W'(ki_s) * ACC_W'(e0_q)
             + ACC_W'(kd_s) * ACC_W'(dd);
        sum  = ACC_W'(uk0_q) + du;

        e0_d  = e;
        e1_d  = e0_q;
        e2_d  = e1_q;
        uk0_d = saturate(sum);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            e2_q  <= '0;
            uk0_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            e2_q  <= e2_d;
            uk0_q <= uk0_d;
        end
    end

    assign uk0 = uk0_q;

endmodule

// File: rtl/demo_top.sv
// rtl/demo_top.sv - PID demo top wrapping a single pid_core
module demo_top
    import pid_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [IN_W-1:0]   target,
    input  logic signed [IN_W-1:0]   y,
    input  logic        [GAIN_W-1:0] kp,
    input  logic        [GAIN_W-1:0] ki,
    input  logic        [GAIN_W-1:0] kd,
    output logic signed [OUT_W-1:0]  uk0
);

    pid_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .target (target),
        .y      (y),
        .kp     (kp),
        .ki     (ki),
        .kd     (kd),
        .uk0    (uk0)
    );

endmodule

// File: tb/tb_demo_top.sv
// tb/tb_demo_top.sv - directed self-checking bench for demo_top
module tb_demo_top;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [9:0]  target;
    logic signed [9:0]  y;
    logic        [3:0]  kp, ki, kd;
    logic signed [14:0] uk0;

    int checks = 0;
    int errors = 0;

    demo_top dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .target (target),
        .y      (y),
        .kp     (kp),
        .ki     (ki),
        .kd     (kd),
        .uk0    (uk0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int exp);
        checks++;
        assert (int'(uk0) === exp) else begin
            errors++;
            $error("FAIL %s: uk0=%0d expected=%0d", tag, uk0, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_in(input int t, input int m, input int p, input int i, input int d);
        target = 10'(t);
        y      = 10'(m);
        kp     = 4'(p);
        ki     = 4'(i);
        kd     = 4'(d);
    endtask

    initial begin
        rst_n = 1'b1;
        set_in(100, 0, 1, 0, 0);

        // Reset with nonzero inputs, then zero error must hold zero.
        do_reset();
        check("reset", 0);
        set_in(0, 0, 5, 5, 5);
        step(); check("reset_hist1", 0);
        step(); check("reset_hist2", 0);

        // Proportional only.
        do_reset();
        set_in(100, 0, 1, 0, 0);
        step(); check("p_edge_k", 0);
        step(); check("p_edge_k1", 100);
        step(); check("p_hold", 100);

        // Integral only, then zero error holds.
        do_reset();
        set_in(100, 0, 0, 1, 0);
        step(); check("i_edge_k", 0);
        step(); check("i_100", 100);
        step(); check("i_200", 200);
        step(); check("i_300", 300);
        set_in(100, 100, 0, 1, 0);
        step(); check("i_last_inc", 400);
        step(); check("i_hold1", 400);
        step(); check("i_hold2", 400);

        // Derivative only.
        do_reset();
        set_in(100, 0, 0, 0, 1);
        step(); check("d_edge_k", 0);
        step(); check("d_kick", 100);
        step(); check("d_back", 0);
        step(); check("d_settle", 0);

        // Negative error through proportional term.
        do_reset();
        set_in(-200, 100, 3, 0, 0);
        step(); check("pneg_edge_k", 0);
        step(); check("pneg", -900);

        // Saturation high, then immediate unwind and clamp low.
        do_reset();
        set_in(511, -512, 0, 15, 0);
        step(); check("sat_edge_k", 0);
        step(); check("sat_first", 15345);
        step(); check("sat_clamp_hi", 16383);
        step(); check("sat_hold_hi", 16383);
        set_in(-512, 511, 0, 15, 0);
        step(); check("sat_rev_k", 16383);
        step(); check("sat_unwind1", 1038);
        step(); check("sat_unwind2", -14307);
        step(); check("sat_clamp_lo", -16384);
        step(); check("sat_hold_lo", -16384);

        // Demo gains.
        do_reset();
        set_in(350, 0, 10, 9, 8);
        step(); check("demo_edge_k", 0);
        step(); check("demo_1", 9450);
        step(); check("demo_2", 9800);
        step(); check("demo_3", 12950);

        // Mid-operation reset discards history.
        set_in(0, 0, 10, 9, 8);
        do_reset();
        check("mid_reset", 0);
        step(); check("mid_reset_hist", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
